mc_control: RTL and testbench

//  Multi-cycle MIPS control unit: successor to the single-cycle decoder; same instruction set plus J.

---
 rtl/mc_control.sv | 256 +++++++++++++++++++++++++
 tb/tb_mc_control.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control
//   Multi-cycle MIPS control unit. A Moore FSM walks each instruction through
//   FETCH / DECODE / execute / memory / write-back over a single shared,
//   wait-stated memory port. It also provides a memory-timeout trap, an
//   illegal-instruction trap and a retired-instruction counter.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   opcode, funct     IR[31:26] and IR[5:0]
//   zero              ALU zero flag (gated into the PC load by the datapath)
//   mem_ready         memory completes the current request this cycle
//   mem_req, mem_we   memory request / write qualifier
//   i_or_d            memory address select (0 = PC, 1 = ALUOut)
//   ir_write          IR load enable
//   pc_write          unconditional PC load
//   pc_wr_cond        PC load qualified by zero (BEQ)
//   pc_src            0 = PC+4, 1 = branch target, 2 = jump target
//   alu_src_a/b       ALU operand selects
//   alu_op, ext_op    ALU function, immediate extension mode
//   reg_dst, mem2reg  write-back destination and data selects
//   reg_write         register-file write enable
//   exc, exc_cause    trap pulse and sticky cause (1 illegal, 2 bus timeout)
//   retired           count of completed instructions (wraps)
// ---------------------------------------------------------------------------
module mc_control #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_wr_cond,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               ext_op,
    output logic               reg_dst,
    output logic               mem2reg,
    output logic               reg_write,
    output logic               exc,
    output logic [1:0]         exc_cause,
    output logic [CNT_W-1:0]   retired
);

    // ALU / extender / destination encodings shared with the datapath
    localparam logic [ALUOP_W-1:0] ALUOP_ADDU = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALUOP_SUBU = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALUOP_ORI  = ALUOP_W'(3);
    localparam logic EXT_ZERO   = 1'b0;
    localparam logic EXT_SIGNED = 1'b1;
    localparam logic REG_DST_RT = 1'b0;
    localparam logic REG_DST_RD = 1'b1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EX_R   = 4'd2;
    localparam logic [3:0] S_EX_ORI = 4'd3;
    localparam logic [3:0] S_ADDR   = 4'd4;
    localparam logic [3:0] S_MEM_RD = 4'd5;
    localparam logic [3:0] S_MEM_WR = 4'd6;
    localparam logic [3:0] S_WB_R   = 4'd7;
    localparam logic [3:0] S_WB_MEM = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_TRAP   = 4'd11;

    localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [3:0]        state;
    logic [3:0]        state_nxt;
    logic [WCNT_W-1:0] wait_cnt;
    logic              in_mem_state;
    logic              mem_wait;
    logic              timeout_hit;
    logic              retire;
    logic              rtype_ok;

    // zero is applied to the PC load inside the datapath, not here
    logic unused_zero;
    assign unused_zero = zero;

    assign rtype_ok     = (funct == FN_ADDU) || (funct == FN_SUBU);
    assign in_mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign mem_wait     = in_mem_state && !mem_ready;
    // The cycle that would push the counter to MEM_TIMEOUT traps instead;
    // a mem_ready on that cycle clears mem_wait and so takes precedence.
    assign timeout_hit  = mem_wait && (wait_cnt == WCNT_W'(MEM_TIMEOUT - 1));

    assign retire = (state == S_WB_R) || (state == S_WB_MEM) ||
                    (state == S_BRANCH) || (state == S_JUMP) ||
                    ((state == S_MEM_WR) && mem_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)        state_nxt = S_DECODE;
                else if (timeout_hit) state_nxt = S_TRAP;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: state_nxt = rtype_ok ? S_EX_R : S_TRAP;
                    OP_ORI:   state_nxt = S_EX_ORI;
                    OP_LW,
                    OP_SW:    state_nxt = S_ADDR;
                    OP_BEQ:   state_nxt = S_BRANCH;
                    OP_J:     state_nxt = S_JUMP;
                    default:  state_nxt = S_TRAP;
                endcase
            end
            S_EX_R,
            S_EX_ORI: state_nxt = S_WB_R;
            S_ADDR:   state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)        state_nxt = S_WB_MEM;
                else if (timeout_hit) state_nxt = S_TRAP;
            end
            S_MEM_WR: begin
                if (mem_ready)        state_nxt = S_FETCH;
                else if (timeout_hit) state_nxt = S_TRAP;
            end
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            exc_cause <= 2'd0;
            retired   <= '0;
        end else begin
            state <= state_nxt;
            // Any state change restarts the count, so each memory state
            // begins its wait budget from zero.
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (mem_wait)
                wait_cnt <= wait_cnt + WCNT_W'(1);
            if (state_nxt == S_TRAP)
                exc_cause <= (state == S_DECODE) ? 2'd1 : 2'd2;
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    // Output decode. Everything is forced low while rst is high so that an
    // aborted instruction cannot leave a write strobe active.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_wr_cond = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = '0;
        ext_op     = 1'b0;
        reg_dst    = 1'b0;
        mem2reg    = 1'b0;
        reg_write  = 1'b0;
        exc        = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'd1;
                    alu_op    = ALUOP_ADDU;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_DECODE: begin
                    // Branch target computed speculatively into ALUOut
                    alu_src_b = 2'd3;
                    ext_op    = EXT_SIGNED;
                    alu_op    = ALUOP_ADDU;
                end
                S_EX_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = (funct == FN_SUBU) ? ALUOP_SUBU : ALUOP_ADDU;
                end
                S_EX_ORI: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    ext_op    = EXT_ZERO;
                    alu_op    = ALUOP_ORI;
                end
                S_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    ext_op    = EXT_SIGNED;
                    alu_op    = ALUOP_ADDU;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    i_or_d  = 1'b1;
                end
                S_WB_R: begin
                    reg_write = 1'b1;
                    // ORI shares this state but writes rt
                    reg_dst   = (opcode == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
                end
                S_WB_MEM: begin
                    reg_write = 1'b1;
                    reg_dst   = REG_DST_RT;
                    mem2reg   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALUOP_SUBU;
                    pc_wr_cond = 1'b1;
                    pc_src     = 2'd1;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end
                S_TRAP: begin
                    exc = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// ---------------------------------------------------------------------------
// tb_mc_control
//   Self-checking bench for mc_control. A per-instruction reference model
//   derives the instruction length and how many cycles each strobe should be
//   active from the instruction class and the memory wait counts; directed
//   tasks add per-cycle checks for the key scenarios. The retired counter is
//   built 4 bits wide so that wrap-around is exercised.
// ---------------------------------------------------------------------------
module tb_mc_control;

    localparam int MT = 16;
    localparam int CW = 4;
    localparam int AW = 4;

    localparam logic [AW-1:0] A_ADDU = 4'd0;
    localparam logic [AW-1:0] A_SUBU = 4'd1;
    localparam logic [AW-1:0] A_ORI  = 4'd3;
    localparam logic RD_SEL = 1'b1;
    localparam logic RT_SEL = 1'b0;

    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LW = 3,
                   K_SW = 4, K_BEQ = 5, K_J = 6, K_ILL = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    opcode = 6'h00;
    logic [5:0]    funct = 6'h00;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, i_or_d, ir_write, pc_write, pc_wr_cond;
    logic [1:0]    pc_src;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [AW-1:0] alu_op;
    logic          ext_op, reg_dst, mem2reg, reg_write, exc;
    logic [1:0]    exc_cause;
    logic [CW-1:0] retired;
    logic [19:0]   all_out;

    mc_control #(.ALUOP_W(AW), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
        .pc_wr_cond(pc_wr_cond), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_op(ext_op),
        .reg_dst(reg_dst), .mem2reg(mem2reg), .reg_write(reg_write),
        .exc(exc), .exc_cause(exc_cause), .retired(retired)
    );

    assign all_out = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_wr_cond,
                      pc_src, alu_src_a, alu_src_b, alu_op, ext_op, reg_dst,
                      mem2reg, reg_write, exc};

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    int exp_ret   = 0;
    int exp_cause = 0;

    // model expectations for the last instruction
    int e_len, e_memreq, e_iord, e_we, e_irw, e_pcw, e_pcwc, e_regw, e_m2r, e_exc;
    // observed tallies for the last instruction
    int t_memreq, t_iord, t_we, t_irw, t_pcw, t_pcwc, t_regw, t_m2r, t_exc;
    // observed per-cycle values
    logic          o_regw  [64];
    logic          o_regdst[64];
    logic          o_m2r   [64];
    logic          o_pcwc  [64];
    logic          o_pcw   [64];
    logic [1:0]    o_pcsrc [64];
    logic          o_srca  [64];
    logic [1:0]    o_srcb  [64];
    logic [AW-1:0] o_aluop [64];
    logic          o_memreq[64];
    logic          o_iord  [64];
    logic          o_irw   [64];
    logic          o_exc   [64];

    // Entered at posedge+1 with the DUT in the first FETCH cycle; returns at
    // posedge+1 of the cycle after the instruction should have finished.
    // fw/dw: wait cycles on fetch / data access; >= MT means never ready.
    task automatic run_instr(input int kind, input logic [5:0] op,
                             input logic [5:0] fn, input int fw, input int dw,
                             input int zmode);
        bit fto, dto, memk;
        int ds;
        logic rdy;
        fto  = (fw >= MT);
        dto  = (dw >= MT);
        memk = ((kind == K_LW) || (kind == K_SW)) && !fto;
        ds   = fw + 3;
        e_memreq = 0; e_iord = 0; e_we = 0; e_irw = 0; e_pcw = 0;
        e_pcwc = 0; e_regw = 0; e_m2r = 0; e_exc = 0;
        if (fto) begin
            e_len = MT + 1; e_memreq = MT; e_exc = 1;
        end else begin
            e_memreq = fw + 1; e_irw = 1; e_pcw = 1;
            case (kind)
                K_ADDU, K_SUBU, K_ORI: begin e_len = fw + 4; e_regw = 1; end
                K_LW, K_SW: begin
                    e_iord   = dto ? MT : dw + 1;
                    e_memreq = e_memreq + e_iord;
                    if (kind == K_SW) e_we = e_iord;
                    if (dto) begin
                        e_len = fw + 20; e_exc = 1;
                    end else if (kind == K_LW) begin
                        e_len = fw + 5 + dw; e_regw = 1; e_m2r = 1;
                    end else begin
                        e_len = fw + 4 + dw;
                    end
                end
                K_BEQ:   begin e_len = fw + 3; e_pcwc = 1; end
                K_J:     begin e_len = fw + 3; e_pcw = 2; end
                default: begin e_len = fw + 3; e_exc = 1; end
            endcase
        end
        if (e_exc == 0) exp_ret = (exp_ret + 1) % (1 << CW);
        else            exp_cause = (kind == K_ILL && !fto) ? 1 : 2;

        opcode = op; funct = fn;
        t_memreq = 0; t_iord = 0; t_we = 0; t_irw = 0; t_pcw = 0;
        t_pcwc = 0; t_regw = 0; t_m2r = 0; t_exc = 0;
        for (int c = 0; c < e_len; c++) begin
            rdy = 1'($urandom_range(0, 1));
            if (fto) begin
                if (c < MT) rdy = 1'b0;
            end else begin
                if (c < fw) rdy = 1'b0;
                else if (c == fw) rdy = 1'b1;
                if (memk && c >= ds) begin
                    if (dto) begin
                        if (c < ds + MT) rdy = 1'b0;
                    end else if (c < ds + dw) rdy = 1'b0;
                    else if (c == ds + dw) rdy = 1'b1;
                end
            end
            mem_ready = rdy;
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : (zmode != 0);
            @(negedge clk);
            o_regw[c] = reg_write; o_regdst[c] = reg_dst; o_m2r[c] = mem2reg;
            o_pcwc[c] = pc_wr_cond; o_pcw[c] = pc_write; o_pcsrc[c] = pc_src;
            o_srca[c] = alu_src_a; o_srcb[c] = alu_src_b; o_aluop[c] = alu_op;
            o_memreq[c] = mem_req; o_iord[c] = i_or_d; o_irw[c] = ir_write;
            o_exc[c] = exc;
            t_memreq += int'(mem_req); t_iord += int'(mem_req & i_or_d);
            t_we += int'(mem_we); t_irw += int'(ir_write); t_pcw += int'(pc_write);
            t_pcwc += int'(pc_wr_cond); t_regw += int'(reg_write);
            t_m2r += int'(mem2reg); t_exc += int'(exc);
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; opcode = 6'h2B;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (all_out !== 20'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h want=00000", all_out);
        end
        n_tests++;
        if (retired !== '0 || exc_cause !== 2'd0) begin
            n_fail++; $display("FAIL reset_regs retired=%0d cause=%0d want 0 0", retired, exc_cause);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({mem_req, i_or_d, alu_src_b, alu_op, ir_write} !== {1'b1, 1'b0, 2'd1, A_ADDU, 1'b0}) begin
            n_fail++; $display("FAIL reset_fetch req=%b iord=%b srcb=%0d aluop=%0d irw=%b want 1 0 1 0 0",
                               mem_req, i_or_d, alu_src_b, alu_op, ir_write);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        run_instr(K_ADDU, 6'h00, 6'h21, 0, 0, -1);
        n_tests++;
        if ({o_regw[0], o_regw[1], o_regw[2], o_regw[3], o_regdst[3]} !== {4'b0001, RD_SEL}) begin
            n_fail++; $display("FAIL addu_wb regw=%b%b%b%b dst=%b want 0001 1",
                               o_regw[0], o_regw[1], o_regw[2], o_regw[3], o_regdst[3]);
        end
        n_tests++;
        if ({o_srca[2], o_srcb[2], o_aluop[2]} !== {1'b1, 2'd0, A_ADDU}) begin
            n_fail++; $display("FAIL addu_ex srca=%b srcb=%0d aluop=%0d", o_srca[2], o_srcb[2], o_aluop[2]);
        end
        n_tests++;
        if (retired !== exp_ret[CW-1:0] || exp_ret != 1) begin
            n_fail++; $display("FAIL addu_retired got=%0d want=1", retired);
        end
        run_instr(K_SUBU, 6'h00, 6'h23, 0, 0, -1);
        n_tests++;
        if (o_aluop[2] !== A_SUBU || o_regdst[3] !== RD_SEL) begin
            n_fail++; $display("FAIL subu aluop=%0d dst=%b want %0d 1", o_aluop[2], o_regdst[3], A_SUBU);
        end
        run_instr(K_ORI, 6'h0D, 6'h15, 0, 0, -1);
        n_tests++;
        if ({o_aluop[2], o_srcb[2], o_regw[3], o_regdst[3]} !== {A_ORI, 2'd2, 1'b1, RT_SEL}) begin
            n_fail++; $display("FAIL ori aluop=%0d srcb=%0d regw=%b dst=%b", o_aluop[2], o_srcb[2], o_regw[3], o_regdst[3]);
        end
    endtask

    task automatic test_lw_wait();
        run_instr(K_LW, 6'h23, 6'h00, 0, 3, -1);
        n_tests++;
        if ({o_memreq[3], o_memreq[4], o_memreq[5], o_memreq[6], t_iord} !== {4'b1111, 32'd4}) begin
            n_fail++; $display("FAIL lw_data_req req=%b%b%b%b iord_cycles=%0d want 1111 4",
                               o_memreq[3], o_memreq[4], o_memreq[5], o_memreq[6], t_iord);
        end
        n_tests++;
        if ({o_regw[7], o_m2r[7], o_regdst[7], t_regw} !== {1'b1, 1'b1, RT_SEL, 32'd1}) begin
            n_fail++; $display("FAIL lw_wb regw=%b m2r=%b dst=%b total_regw=%0d", o_regw[7], o_m2r[7], o_regdst[7], t_regw);
        end
        n_tests++;
        if (mem_req !== 1'b1 || i_or_d !== 1'b0 || retired !== exp_ret[CW-1:0]) begin
            n_fail++; $display("FAIL lw_len8 req=%b iord=%b retired=%0d want 1 0 %0d", mem_req, i_or_d, retired, exp_ret);
        end
    endtask

    task automatic test_branch_jump();
        for (int z = 1; z >= 0; z--) begin
            run_instr(K_BEQ, 6'h04, 6'h00, 0, 0, z);
            n_tests++;
            if ({o_pcwc[2], o_pcsrc[2], o_aluop[2], t_pcw, t_regw} !== {1'b1, 2'd1, A_SUBU, 32'd1, 32'd0}) begin
                n_fail++; $display("FAIL beq_z%0d pcwc=%b pcsrc=%0d aluop=%0d pcw=%0d regw=%0d",
                                   z, o_pcwc[2], o_pcsrc[2], o_aluop[2], t_pcw, t_regw);
            end
            n_tests++;
            if (retired !== exp_ret[CW-1:0] || mem_req !== 1'b1) begin
                n_fail++; $display("FAIL beq_z%0d_retire retired=%0d req=%b want %0d 1", z, retired, mem_req, exp_ret);
            end
        end
        run_instr(K_J, 6'h02, 6'h00, 0, 0, -1);
        n_tests++;
        if ({o_pcw[2], o_pcsrc[2], retired} !== {1'b1, 2'd2, exp_ret[CW-1:0]}) begin
            n_fail++; $display("FAIL jump pcw=%b pcsrc=%0d retired=%0d want 1 2 %0d", o_pcw[2], o_pcsrc[2], retired, exp_ret);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2];
        logic [5:0] fns [2];
        ops[0] = 6'h3F; fns[0] = 6'h21;
        ops[1] = 6'h00; fns[1] = 6'h20;
        for (int i = 0; i < 2; i++) begin
            run_instr(K_ILL, ops[i], fns[i], 0, 0, -1);
            n_tests++;
            if ({o_exc[1], o_exc[2], t_exc, t_regw, t_pcw} !== {2'b01, 32'd1, 32'd0, 32'd1}) begin
                n_fail++; $display("FAIL illegal_%0d exc=%b%b total_exc=%0d regw=%0d pcw=%0d",
                                   i, o_exc[1], o_exc[2], t_exc, t_regw, t_pcw);
            end
            n_tests++;
            if (exc_cause !== 2'd1 || retired !== exp_ret[CW-1:0] || mem_req !== 1'b1 || i_or_d !== 1'b0) begin
                n_fail++; $display("FAIL illegal_%0d_after cause=%0d retired=%0d req=%b want 1 %0d 1",
                                   i, exc_cause, retired, mem_req, exp_ret);
            end
        end
    endtask

    task automatic test_timeout();
        run_instr(K_ADDU, 6'h00, 6'h21, MT, 0, -1);
        n_tests++;
        if ({o_exc[MT-1], o_exc[MT], t_irw, exc_cause} !== {2'b01, 32'd0, 2'd2}) begin
            n_fail++; $display("FAIL fetch_timeout exc=%b%b irw=%0d cause=%0d want 01 0 2",
                               o_exc[MT-1], o_exc[MT], t_irw, exc_cause);
        end
        n_tests++;
        if (retired !== exp_ret[CW-1:0] || mem_req !== 1'b1) begin
            n_fail++; $display("FAIL fetch_timeout_after retired=%0d req=%b want %0d 1", retired, mem_req, exp_ret);
        end
        run_instr(K_ADDU, 6'h00, 6'h21, MT - 1, 0, -1);
        n_tests++;
        if ({t_exc, o_irw[MT-1], retired} !== {32'd0, 1'b1, exp_ret[CW-1:0]}) begin
            n_fail++; $display("FAIL fetch_last_ready exc=%0d irw=%b retired=%0d want 0 1 %0d",
                               t_exc, o_irw[MT-1], retired, exp_ret);
        end
        run_instr(K_SW, 6'h2B, 6'h00, 0, MT, -1);
        n_tests++;
        if ({t_we, t_exc, exc_cause, retired} !== {32'd16, 32'd1, 2'd2, exp_ret[CW-1:0]}) begin
            n_fail++; $display("FAIL sw_timeout we=%0d exc=%0d cause=%0d retired=%0d want 16 1 2 %0d",
                               t_we, t_exc, exc_cause, retired, exp_ret);
        end
    endtask

    task automatic test_random();
        int kind, fw, dw, r;
        logic [5:0] op, fn;
        logic [71:0] got, want;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 7);
            r = $urandom_range(0, 11);
            fw = (r == 0) ? MT : (r == 1) ? MT - 1 : $urandom_range(0, 3);
            r = $urandom_range(0, 7);
            dw = (r == 0) ? MT : $urandom_range(0, 4);
            fn = 6'($urandom_range(0, 63));
            case (kind)
                K_ADDU: begin op = 6'h00; fn = 6'h21; end
                K_SUBU: begin op = 6'h00; fn = 6'h23; end
                K_ORI:  op = 6'h0D;
                K_LW:   op = 6'h23;
                K_SW:   op = 6'h2B;
                K_BEQ:  op = 6'h04;
                K_J:    op = 6'h02;
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        op = 6'h00;
                        while (fn == 6'h21 || fn == 6'h23) fn = 6'($urandom_range(0, 63));
                    end else begin
                        op = 6'($urandom_range(0, 63));
                        while (op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h0D ||
                               op == 6'h23 || op == 6'h2B) op = 6'($urandom_range(0, 63));
                    end
                end
            endcase
            run_instr(kind, op, fn, fw, dw, -1);
            got  = {t_memreq[7:0], t_iord[7:0], t_we[7:0], t_irw[7:0], t_pcw[7:0],
                    t_pcwc[7:0], t_regw[7:0], t_m2r[7:0], t_exc[7:0]};
            want = {e_memreq[7:0], e_iord[7:0], e_we[7:0], e_irw[7:0], e_pcw[7:0],
                    e_pcwc[7:0], e_regw[7:0], e_m2r[7:0], e_exc[7:0]};
            n_tests++;
            if (got !== want) begin
                n_fail++; $display("FAIL rand%0d_strobes op=%h fn=%h fw=%0d dw=%0d got=%h want=%h",
                                   n, op, fn, fw, dw, got, want);
            end
            n_tests++;
            if (retired !== exp_ret[CW-1:0] || exc_cause !== exp_cause[1:0]) begin
                n_fail++; $display("FAIL rand%0d_regs retired=%0d cause=%0d want %0d %0d",
                                   n, retired, exc_cause, exp_ret, exp_cause);
            end
            n_tests++;
            if (mem_req !== 1'b1 || i_or_d !== 1'b0 || alu_src_b !== 2'd1) begin
                n_fail++; $display("FAIL rand%0d_refetch req=%b iord=%b srcb=%0d want 1 0 1",
                                   n, mem_req, i_or_d, alu_src_b);
            end
        end
    endtask

    task automatic test_rst_mid();
        run_instr(K_ILL, 6'h3F, 6'h00, 0, 0, -1);
        run_instr(K_ADDU, 6'h00, 6'h21, 0, 0, -1);
        if (exp_ret == 0) run_instr(K_ADDU, 6'h00, 6'h21, 0, 0, -1);
        opcode = 6'h2B; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if ({mem_req, mem_we, i_or_d} !== 3'b111) begin
            n_fail++; $display("FAIL rst_mid_pre req=%b we=%b iord=%b want 111", mem_req, mem_we, i_or_d);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({mem_req, mem_we} !== 2'b00) begin
            n_fail++; $display("FAIL rst_mid_drop req=%b we=%b want 00", mem_req, mem_we);
        end
        @(negedge clk);
        n_tests++;
        if (all_out !== 20'd0) begin
            n_fail++; $display("FAIL rst_mid_outputs got=%h want=00000", all_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ret = 0; exp_cause = 0;
        #1;
        n_tests++;
        if ({retired, exc_cause, mem_req, i_or_d, mem_we} !== {exp_ret[CW-1:0], exp_cause[1:0], 3'b100}) begin
            n_fail++; $display("FAIL rst_mid_after retired=%0d cause=%0d req=%b iord=%b we=%b want 0 0 1 0 0",
                               retired, exc_cause, mem_req, i_or_d, mem_we);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch_jump();
        test_illegal();
        test_timeout();
        test_random();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard bound on run time in case the bench itself stalls
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
